// File: rtl/eth_pkg.sv
// Shared types and line constants for the Ethernet TX front stage.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_FRAME    = 3'd3,
        ST_IFG      = 3'd4
    } eth_state_t;

    typedef enum logic {
        FT_ARP = 1'b0,
        FT_IP  = 1'b1
    } eth_frame_t;

    localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/eth_preamble_sfd_tx.sv
// Grants ARP/IP frames (ARP first), sends preamble + SFD, hands off, then holds the inter-frame gap.
// Ack and first preamble byte appear one cycle after the grant is sampled; all outputs registered.
module eth_preamble_sfd_tx
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IFG_LEN      = 12
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       arp_req,
    input  logic       ip_req,
    input  logic       frame_done,
    output logic       arp_ack,
    output logic       ip_ack,
    output logic [7:0] pre_txd,
    output logic       pre_tx_en,
    output logic       preamble_sfd_tx_valid,
    output logic       arp_resp_start,
    output logic       ip_start,
    output logic       busy
);

    eth_state_t r_state;
    eth_frame_t r_type;
    logic [3:0] r_pre_cnt;
    logic [4:0] r_ifg_cnt;
    logic       r_arp_ack;
    logic       r_ip_ack;
    logic [7:0] r_txd;
    logic       r_tx_en;
    logic       r_valid;
    logic       r_arp_start;
    logic       r_ip_start;
    logic       r_busy;

    eth_state_t w_state;
    eth_frame_t w_type;
    logic [3:0] w_pre_cnt;
    logic [4:0] w_ifg_cnt;
    logic       w_arp_ack;
    logic       w_ip_ack;
    logic [7:0] w_txd;
    logic       w_tx_en;
    logic       w_valid;
    logic       w_arp_start;
    logic       w_ip_start;

    always_comb begin
        w_state     = r_state;
        w_type      = r_type;
        w_pre_cnt   = r_pre_cnt;
        w_ifg_cnt   = r_ifg_cnt;
        w_arp_ack   = 1'b0;
        w_ip_ack    = 1'b0;
        w_txd       = 8'h00;
        w_tx_en     = 1'b0;
        w_valid     = 1'b0;
        w_arp_start = 1'b0;
        w_ip_start  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (arp_req || ip_req) begin
                    w_arp_ack = arp_req;
                    w_ip_ack  = ~arp_req;
                    w_type    = arp_req ? FT_ARP : FT_IP;
                    w_state   = ST_PREAMBLE;
                    w_pre_cnt = 4'd1;
                    w_txd     = ETH_PREAMBLE_BYTE;
                    w_tx_en   = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                // r_pre_cnt holds the number of preamble bytes already on the line
                w_tx_en = 1'b1;
                if (r_pre_cnt == 4'(PREAMBLE_LEN)) begin
                    w_state = ST_SFD;
                    w_txd   = ETH_SFD_BYTE;
                end else begin
                    w_pre_cnt = r_pre_cnt + 4'd1;
                    w_txd     = ETH_PREAMBLE_BYTE;
                end
            end
            ST_SFD: begin
                w_state     = ST_FRAME;
                w_pre_cnt   = 4'd0;
                w_valid     = 1'b1;
                w_arp_start = (r_type == FT_ARP);
                w_ip_start  = (r_type == FT_IP);
            end
            ST_FRAME: begin
                // The frame_done cycle is the first gap cycle, so IFG holds IFG_LEN-1 more
                if (frame_done) begin
                    if (IFG_LEN == 1) begin
                        w_state = ST_IDLE;
                    end else begin
                        w_state   = ST_IFG;
                        w_ifg_cnt = 5'd1;
                    end
                end
            end
            ST_IFG: begin
                if (r_ifg_cnt == 5'(IFG_LEN - 1)) begin
                    w_state   = ST_IDLE;
                    w_ifg_cnt = 5'd0;
                end else begin
                    w_ifg_cnt = r_ifg_cnt + 5'd1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_type      <= FT_ARP;
            r_pre_cnt   <= 4'd0;
            r_ifg_cnt   <= 5'd0;
            r_arp_ack   <= 1'b0;
            r_ip_ack    <= 1'b0;
            r_txd       <= 8'h00;
            r_tx_en     <= 1'b0;
            r_valid     <= 1'b0;
            r_arp_start <= 1'b0;
            r_ip_start  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_type      <= w_type;
            r_pre_cnt   <= w_pre_cnt;
            r_ifg_cnt   <= w_ifg_cnt;
            r_arp_ack   <= w_arp_ack;
            r_ip_ack    <= w_ip_ack;
            r_txd       <= w_txd;
            r_tx_en     <= w_tx_en;
            r_valid     <= w_valid;
            r_arp_start <= w_arp_start;
            r_ip_start  <= w_ip_start;
            r_busy      <= (w_state != ST_IDLE);
        end
    end

    assign arp_ack               = r_arp_ack;
    assign ip_ack                = r_ip_ack;
    assign pre_txd               = r_txd;
    assign pre_tx_en             = r_tx_en;
    assign preamble_sfd_tx_valid = r_valid;
    assign arp_resp_start        = r_arp_start;
    assign ip_start              = r_ip_start;
    assign busy                  = r_busy;

endmodule

// File: tb/tb_eth_preamble_sfd_tx.sv
// Bench for eth_preamble_sfd_tx: default (7/12) and short (3/1) instances against a cycle-timeline model.
module tb_eth_preamble_sfd_tx;

    localparam int MAXC = 4096;
    localparam int P0 = 7;
    localparam int G0 = 12;
    localparam int P1 = 3;
    localparam int G1 = 1;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic       arp_req [2];
    logic       ip_req  [2];
    logic       fdone   [2];
    logic       arp_ack [2];
    logic       ip_ack  [2];
    logic [7:0] txd     [2];
    logic       tx_en   [2];
    logic       vld     [2];
    logic       arp_st  [2];
    logic       ip_st   [2];
    logic       busy    [2];

    eth_preamble_sfd_tx #(.PREAMBLE_LEN(P0), .IFG_LEN(G0)) u_dut0 (
        .aclk(aclk), .areset(areset),
        .arp_req(arp_req[0]), .ip_req(ip_req[0]), .frame_done(fdone[0]),
        .arp_ack(arp_ack[0]), .ip_ack(ip_ack[0]),
        .pre_txd(txd[0]), .pre_tx_en(tx_en[0]),
        .preamble_sfd_tx_valid(vld[0]),
        .arp_resp_start(arp_st[0]), .ip_start(ip_st[0]), .busy(busy[0])
    );

    eth_preamble_sfd_tx #(.PREAMBLE_LEN(P1), .IFG_LEN(G1)) u_dut1 (
        .aclk(aclk), .areset(areset),
        .arp_req(arp_req[1]), .ip_req(ip_req[1]), .frame_done(fdone[1]),
        .arp_ack(arp_ack[1]), .ip_ack(ip_ack[1]),
        .pre_txd(txd[1]), .pre_tx_en(tx_en[1]),
        .preamble_sfd_tx_valid(vld[1]),
        .arp_resp_start(arp_st[1]), .ip_start(ip_st[1]), .busy(busy[1])
    );

    // Expected per-cycle outputs (busy excluded):
    // [13] arp_ack [12] ip_ack [11:4] txd [3] tx_en [2] valid [1] arp_start [0] ip_start
    logic [13:0] exp_v [2][MAXC];
    int  m_plen [2];
    int  m_glen [2];
    bit  m_active [2];
    int  m_idle_from [2];
    int  m_frame_from [2];
    int  m_grant [2];

    int cyc;
    int n_pass;
    int n_fail;
    int n_total;

    function automatic logic [14:0] obs(int i);
        return {arp_ack[i], ip_ack[i], txd[i], tx_en[i], vld[i], arp_st[i], ip_st[i], busy[i]};
    endfunction

    task automatic check(input string tag, input int i, input logic [14:0] expv);
        logic [14:0] o;
        o = obs(i);
        n_total++;
        assert (o === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s inst%0d cyc%0d: observed %h expected %h", tag, i, cyc, o, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < MAXC; k++) exp_v[i][k] = '0;
            m_active[i]     = 1'b0;
            m_idle_from[i]  = 1 << 30;
            m_frame_from[i] = 1 << 30;
            m_grant[i]      = 0;
        end
    endtask

    // A request seen while idle schedules the whole preamble timeline; a
    // frame_done seen on or after the FRAME entry ends the frame and opens
    // the gap, after which the instance is idle again.
    task automatic model_update(input int i, input logic a, input logic r, input logic f);
        int k;
        int p;
        k = cyc;
        p = m_plen[i];
        if (!m_active[i] && k >= m_idle_from[i]) begin
            if (a || r) begin
                if (k + p + 2 < MAXC) begin
                    exp_v[i][k + 1][a ? 13 : 12] = 1'b1;
                    for (int j = 1; j <= p; j++) exp_v[i][k + j][11:3] = {8'h55, 1'b1};
                    exp_v[i][k + p + 1][11:3] = {8'hD5, 1'b1};
                    exp_v[i][k + p + 2][2] = 1'b1;
                    exp_v[i][k + p + 2][a ? 1 : 0] = 1'b1;
                end
                m_active[i]     = 1'b1;
                m_grant[i]      = k;
                m_frame_from[i] = k + p + 2;
            end
        end else if (m_active[i] && k >= m_frame_from[i] && f) begin
            m_active[i]    = 1'b0;
            m_idle_from[i] = k + m_glen[i];
        end
    endtask

    task automatic check_cycle();
        for (int i = 0; i < 2; i++) begin
            logic b;
            b = m_active[i] ? 1'b1 : (cyc < m_idle_from[i]);
            if (cyc < MAXC) check("cycle", i, {exp_v[i][cyc], b});
        end
    endtask

    // fd_mode: 0 none, 1 on the modelled FRAME entry cycle, 2 random, 3 forced pulse
    task automatic drive(input logic a0, input logic r0, input logic a1, input logic r1, input int fd_mode);
        for (int i = 0; i < 2; i++) begin
            logic a;
            logic r;
            logic f;
            a = (i == 0) ? a0 : a1;
            r = (i == 0) ? r0 : r1;
            case (fd_mode)
                1:       f = m_active[i] && (cyc == m_frame_from[i]);
                2:       f = ($urandom_range(0, 3) == 0);
                3:       f = 1'b1;
                default: f = 1'b0;
            endcase
            arp_req[i] = a;
            ip_req[i]  = r;
            fdone[i]   = f;
            model_update(i, a, r, f);
        end
    endtask

    task automatic step(input logic a0, input logic r0, input logic a1, input logic r1, input int fd_mode);
        @(posedge aclk);
        cyc++;
        @(negedge aclk);
        check_cycle();
        drive(a0, r0, a1, r1, fd_mode);
    endtask

    initial begin
        bit ra [2];
        bit ri [2];
        int g;
        n_pass = 0;
        n_fail = 0;
        n_total = 0;
        cyc = 0;
        m_plen[0] = P0; m_glen[0] = G0;
        m_plen[1] = P1; m_glen[1] = G1;
        for (int i = 0; i < 2; i++) begin
            arp_req[i] = 1'b0; ip_req[i] = 1'b0; fdone[i] = 1'b0;
            ra[i] = 1'b0; ri[i] = 1'b0;
        end
        model_clear();

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        for (int i = 0; i < 2; i++) check("reset", i, 15'h0);
        areset = 1'b0;
        for (int i = 0; i < 2; i++) m_idle_from[i] = cyc;
        drive(0, 0, 0, 0, 0);

        // IP-only frame, one frame_done while both instances sit in FRAME
        repeat (10) step(0, 1, 0, 1, 0);
        repeat (8)  step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 3);
        repeat (14) step(0, 0, 0, 0, 0);

        // ARP and IP together: ARP wins, IP follows after the gap; frame_done on FRAME entry
        step(1, 1, 1, 1, 1);
        repeat (40) step(0, 1, 0, 1, 1);
        repeat (15) step(0, 0, 0, 0, 1);

        // Asynchronous reset during the fourth preamble byte of the default instance
        step(1, 0, 1, 0, 0);
        g = m_grant[0];
        while (cyc < g + 4) step(1, 0, 1, 0, 0);
        areset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) check("async_reset", i, 15'h0);
        model_clear();
        repeat (2) begin
            @(posedge aclk);
            cyc++;
        end
        @(negedge aclk);
        areset = 1'b0;
        for (int i = 0; i < 2; i++) m_idle_from[i] = cyc;
        drive(1, 0, 1, 0, 0);
        repeat (12) step(1, 0, 1, 0, 0);
        repeat (4)  step(0, 0, 0, 0, 1);

        // Random request levels and frame_done pulses in every state
        repeat (1500) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 7) == 0) ra[i] = ~ra[i];
                if ($urandom_range(0, 7) == 0) ri[i] = ~ri[i];
            end
            step(ra[0], ri[0], ra[1], ri[1], 2);
        end
        repeat (60) step(0, 0, 0, 0, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
